// File: rtl/vlc_pkg.sv
// Shared types, pad constants and width helpers for the VLC stream packer.
package vlc_pkg;

  localparam bit PAD_ZERO = 1'b0;
  localparam bit PAD_ONE  = 1'b1;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } vlc_state_t;

  function automatic int vlc_len_w(input int code_w);
    return $clog2(code_w + 1) + 1;
  endfunction

  function automatic int vlc_cnt_w(input int out_w, input int code_w);
    return $clog2(out_w + code_w);
  endfunction

  function automatic int vlc_bytes_w(input int out_w);
    return $clog2(out_w / 8 + 1);
  endfunction

endpackage

// File: rtl/vlc_mask_align.sv
// Clamps a code length, masks the code to that length and places it directly
// below the bits already held at the top of the accumulator.
module vlc_mask_align #(
  parameter int CODE_W = 16,
  parameter int LEN_W  = 6,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 6
) (
  input  logic [CODE_W-1:0] i_code,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [CNT_W-1:0]  i_cnt,
  output logic [ACC_W-1:0]  o_aligned,
  output logic [LEN_W-1:0]  o_len,
  output logic              o_clamp
);

  localparam int SH_W = CNT_W + 1;

  logic [CODE_W-1:0] w_mask;
  logic [SH_W-1:0]   w_shift;

  always_comb begin
    o_clamp   = i_len > LEN_W'(CODE_W);
    o_len     = o_clamp ? LEN_W'(CODE_W) : i_len;
    w_mask    = ~({CODE_W{1'b1}} << o_len);
    // Only meaningful while cnt < OUT_W, i.e. whenever a symbol can be accepted.
    w_shift   = SH_W'(ACC_W) - SH_W'(i_cnt) - SH_W'(o_len);
    o_aligned = ACC_W'(i_code & w_mask) << w_shift;
  end

endmodule

// File: rtl/vlc_stream_packer.sv
// Packs variable-length codes MSB-first into OUT_W-bit words; on in_last the
// tail is byte-aligned, padded and tagged as the final word of the block.
module vlc_stream_packer
  import vlc_pkg::*;
#(
  parameter int CODE_W   = 16,
  parameter int LEN_W    = vlc_len_w(CODE_W),
  parameter int OUT_W    = 32,
  parameter bit PAD_ONES = PAD_ZERO
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CODE_W-1:0]             in_code,
  input  logic [LEN_W-1:0]              in_len,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic [vlc_bytes_w(OUT_W)-1:0] out_bytes,
  output logic                          out_last,
  output logic                          err_len
);

  localparam int ACC_W   = OUT_W + CODE_W;
  localparam int CNT_W   = vlc_cnt_w(OUT_W, CODE_W);
  localparam int BYTES_W = vlc_bytes_w(OUT_W);
  localparam int SH_W    = CNT_W + 1;
  localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_W);
  localparam logic [OUT_W-1:0] ONES    = '1;

  vlc_state_t          r_state, w_state_nxt;
  logic [ACC_W-1:0]    r_acc, w_acc_nxt, w_aligned;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0]    w_len;
  logic                w_clamp;
  logic                w_accept, w_free;
  logic                r_out_valid, r_out_last, r_err_len;
  logic [OUT_W-1:0]    r_out_data, w_ld_data, w_tail_pad;
  logic [BYTES_W-1:0]  r_out_bytes, w_ld_bytes, w_tail_bytes;
  logic                w_ld, w_ld_last;
  logic [SH_W-1:0]     w_bnd;

  vlc_mask_align #(
    .CODE_W (CODE_W),
    .LEN_W  (LEN_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) u_align (
    .i_code    (in_code),
    .i_len     (in_len),
    .i_cnt     (r_cnt),
    .o_aligned (w_aligned),
    .o_len     (w_len),
    .o_clamp   (w_clamp)
  );

  assign in_ready = (r_state == RUN) && (r_cnt < OUT_CNT);
  assign w_accept = in_valid && in_ready;
  assign w_free   = !r_out_valid || out_ready;

  // Pad covers bits from cnt up to the next byte boundary; lower bits stay 0.
  always_comb begin
    w_bnd        = (SH_W'(r_cnt) + SH_W'(7)) & ~SH_W'(7);
    w_tail_bytes = BYTES_W'(w_bnd >> 3);
    w_tail_pad   = '0;
    if (PAD_ONES)
      w_tail_pad = (ONES >> r_cnt) & ~(ONES >> w_bnd);
  end

  // Accept and word transfer are mutually exclusive: one needs cnt < OUT_W,
  // the other cnt >= OUT_W.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ld        = 1'b0;
    w_ld_data   = '0;
    w_ld_bytes  = '0;
    w_ld_last   = 1'b0;
    if (w_accept) begin
      w_acc_nxt = r_acc | w_aligned;
      w_cnt_nxt = r_cnt + CNT_W'(w_len);
      if (in_last)
        w_state_nxt = FLUSH;
    end else if (w_free && (r_cnt >= OUT_CNT)) begin
      w_ld       = 1'b1;
      w_ld_data  = r_acc[ACC_W-1 -: OUT_W];
      w_ld_bytes = BYTES_W'(OUT_W / 8);
      w_acc_nxt  = r_acc << OUT_W;
      w_cnt_nxt  = r_cnt - OUT_CNT;
      if ((r_state == FLUSH) && (r_cnt == OUT_CNT)) begin
        w_ld_last   = 1'b1;
        w_state_nxt = RUN;
      end
    end else if (w_free && (r_state == FLUSH)) begin
      // Tail word; with cnt==0 this degenerates to the empty last word.
      w_ld        = 1'b1;
      w_ld_data   = r_acc[ACC_W-1 -: OUT_W] | w_tail_pad;
      w_ld_bytes  = w_tail_bytes;
      w_ld_last   = 1'b1;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_bytes <= '0;
      r_out_last  <= 1'b0;
    end else if (w_ld) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ld_data;
      r_out_bytes <= w_ld_bytes;
      r_out_last  <= w_ld_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_err_len <= 1'b0;
    else if (w_accept && w_clamp) r_err_len <= 1'b1;
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_bytes = r_out_bytes;
  assign out_last  = r_out_last;
  assign err_len   = r_err_len;

endmodule

// File: tb/tb_vlc_stream_packer.sv
// Bench for vlc_stream_packer: bit-queue reference model plus directed literals.
module tb_vlc_stream_packer;

  localparam int CODE_W  = 16;
  localparam int OUT_W   = 32;
  localparam int LEN_W   = $clog2(CODE_W + 1) + 1;
  localparam int BYTES_W = $clog2(OUT_W / 8 + 1);

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    int          bytes;
    bit          last;
  } word_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic               out_ready = 1'b1;
  logic [15:0]        in_code = '0;
  logic [LEN_W-1:0]   in_len = '0;
  logic               in_ready, out_valid, out_last, err_len;
  logic               in_ready1, out_valid1, out_last1, err_len1;
  logic [31:0]        out_data, out_data1;
  logic [BYTES_W-1:0] out_bytes, out_bytes1;

  int          n_chk = 0;
  int          n_fail = 0;
  bit          rdy_rand = 1'b0;
  bit          bitq[$];
  word_t       exp_q[$];
  word_t       got[$];
  word_t       cg, ce;
  bit          prev_stall = 1'b0;
  logic [31:0] hold_d;
  logic [BYTES_W-1:0] hold_b;
  logic        hold_l;

  always #5 clk = ~clk;

  vlc_stream_packer #(.CODE_W(CODE_W), .OUT_W(OUT_W), .PAD_ONES(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_len(in_len), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bytes(out_bytes), .out_last(out_last), .err_len(err_len)
  );

  vlc_stream_packer #(.CODE_W(CODE_W), .OUT_W(OUT_W), .PAD_ONES(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_code(in_code), .in_len(in_len), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_bytes(out_bytes1), .out_last(out_last1), .err_len(err_len1)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endfunction

  // Reference: stream of bits; words cut every OUT_W bits, tail padded on last.
  function automatic void model_sym(input logic [15:0] c, input int l, input bit last);
    int    len;
    bit    made;
    word_t w;
    len  = (l > CODE_W) ? CODE_W : l;
    made = 1'b0;
    for (int i = len - 1; i >= 0; i--) bitq.push_back(c[i]);
    while (bitq.size() >= OUT_W) begin
      w.d0 = '0;
      for (int i = 0; i < OUT_W; i++) w.d0 = {w.d0[30:0], bitq.pop_front()};
      w.d1 = w.d0; w.bytes = OUT_W / 8; w.last = 1'b0;
      exp_q.push_back(w);
      made = 1'b1;
    end
    if (last) begin
      if (made && bitq.size() == 0) begin
        exp_q[exp_q.size()-1].last = 1'b1;
      end else begin
        int n, nb;
        n  = bitq.size();
        nb = (n + 7) / 8;
        w.d0 = '0; w.d1 = '0;
        for (int i = 0; i < OUT_W; i++) begin
          w.d0[OUT_W-1-i] = (i < n) ? bitq[i] : 1'b0;
          w.d1[OUT_W-1-i] = (i < n) ? bitq[i] : (i < 8 * nb);
        end
        w.bytes = nb; w.last = 1'b1;
        exp_q.push_back(w);
        bitq.delete();
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_data", out_data, hold_d);
        chk("hold_bytes", out_bytes, hold_b);
        chk("hold_last", out_last, hold_l);
      end
      if (out_valid && out_ready) begin
        cg.d0 = out_data; cg.d1 = out_data1; cg.bytes = out_bytes; cg.last = out_last;
        got.push_back(cg);
        chk("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          ce = exp_q.pop_front();
          chk("word_data", out_data, ce.d0);
          chk("word_bytes", out_bytes, ce.bytes);
          chk("word_last", out_last, ce.last);
          chk("pad1_valid", out_valid1, 1);
          chk("pad1_data", out_data1, ce.d1);
          chk("pad1_bytes", out_bytes1, ce.bytes);
          chk("pad1_last", out_last1, ce.last);
        end
      end
      prev_stall = out_valid && !out_ready;
      hold_d = out_data; hold_b = out_bytes; hold_l = out_last;
      if (in_valid && in_ready) model_sym(in_code, int'(in_len), in_last);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [15:0] c, input int l, input bit last);
    int n;
    n = 0;
    in_valid = 1'b1; in_code = c; in_len = LEN_W'(l); in_last = last;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("send_accept", in_ready, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      tick();
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  function automatic void chk_got(input string nm, input int idx, input logic [31:0] d0,
                                  input logic [31:0] d1, input int b, input bit l);
    chk({nm, "_present"}, got.size() > idx, 1);
    if (got.size() > idx) begin
      chk({nm, "_data"}, got[idx].d0, d0);
      chk({nm, "_data_pad1"}, got[idx].d1, d1);
      chk({nm, "_bytes"}, got[idx].bytes, b);
      chk({nm, "_last"}, got[idx].last, l);
    end
  endfunction

  function automatic void chk_reset(input string p);
    chk({p, "_in_ready"}, in_ready, 1);
    chk({p, "_out_valid"}, out_valid, 0);
    chk({p, "_out_data"}, out_data, 0);
    chk({p, "_out_bytes"}, out_bytes, 0);
    chk({p, "_out_last"}, out_last, 0);
    chk({p, "_err_len"}, err_len, 0);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    #3 rst = 1'b0;
    tick();

    // Packing: five symbols fill exactly one word.
    g = got.size();
    send(16'h0005, 3, 0);
    send(16'hABCD, 16, 0);
    send(16'h0003, 2, 0);
    send(16'h007F, 7, 0);
    send(16'h0001, 4, 0);
    chk("bubble_in_ready", in_ready, 0);
    tick();
    chk("after_in_ready", in_ready, 1);
    chk("after_out_valid", out_valid, 1);
    drain();
    chk_got("pack", g, 32'hB579BFF1, 32'hB579BFF1, 4, 0);

    g = got.size();
    send(16'h0005, 3, 1);
    drain();
    chk_got("tail", g, 32'hA0000000, 32'hBF000000, 1, 1);

    // Exact fit, then an empty block.
    g = got.size();
    send(16'hFFFF, 16, 0);
    send(16'h0001, 16, 1);
    drain();
    repeat (4) tick();
    chk("fit_count", got.size() - g, 1);
    chk_got("fit", g, 32'hFFFF0001, 32'hFFFF0001, 4, 1);
    g = got.size();
    send(16'h1234, 0, 1);
    drain();
    chk_got("empty", g, 32'h0, 32'h0, 0, 1);

    // Over-long length is clamped and flagged.
    chk("err_init", err_len, 0);
    g = got.size();
    send(16'hFFFF, 20, 0);
    chk("err_set", err_len, 1);
    send(16'h0003, 2, 0);
    send(16'h0001, 1, 1);
    drain();
    chk("err_sticky", err_len, 1);
    chk("err_sticky_pad1", err_len1, 1);
    chk_got("clamp", g, 32'hFFFFE000, 32'hFFFFFF00, 3, 1);

    // Random symbols under random backpressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++)
      send(16'($urandom), int'($urandom_range(0, 16)), (i == 39) || ($urandom_range(0, 7) == 0));
    drain();
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    tick();

    // Stall with a full register and a full accumulator, then reset mid-block.
    out_ready = 1'b0;
    send(16'h1234, 16, 0);
    send(16'h5678, 16, 0);
    send(16'h9ABC, 16, 0);
    send(16'hDEF0, 16, 0);
    repeat (4) tick();
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_out_data", out_data, 32'h12345678);
    #2 rst = 1'b1;
    #1;
    chk_reset("async_rst");
    exp_q.delete();
    bitq.delete();
    tick();
    tick();
    #2 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    g = got.size();
    send(16'h0005, 3, 1);
    drain();
    chk_got("post_rst", g, 32'hA0000000, 32'hBF000000, 1, 1);
    chk("err_cleared", err_len, 0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vlc_stream_packer.md
Name: vlc_stream_packer

Overview:
- Sequential, parametrised successor to the combinational 64-entry packer.
- Accepts one variable-length code (code, length) per cycle over a valid/ready handshake.
- Concatenates codes MSB-first into a continuous bitstream and emits fixed-width output words.
- On end-of-block, byte-aligns and pads the tail, then tags the final word. It sits between the per-coefficient code generators and the byte-stream writer.

Parameters:
- CODE_W, 16: maximum code length in bits; in_code width.
- LEN_W, $clog2(CODE_W+1)+1: in_len width. Derived; do not override.
- OUT_W, 32: output word width. Must be a multiple of 8 and >= CODE_W.
- PAD_ONES, 0: tail pad bit value. 0 pads with zeros; 1 pads with ones (JPEG-style).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  symbol valid
- in_ready  out  1  packer can accept a symbol
- in_code  in  CODE_W  code, right-justified; bits at or above in_len are ignored
- in_len  in  LEN_W  code length 0..CODE_W
- in_last  in  1  last symbol of the block; triggers flush
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the word
- out_data  out  OUT_W  packed bits; first stream bit at out_data[OUT_W-1]
- out_bytes  out  $clog2(OUT_W/8+1)  count of valid bytes in out_data, MSB-first
- out_last  out  1  final word of the block
- err_len  out  1  sticky: some in_len exceeded CODE_W

Behaviour:
- Reset (async, all state):
  - in_ready=1, out_valid=0, out_data=0, out_bytes=0, out_last=0, err_len=0.
  - Accumulator count=0, state=RUN.
  - Reset mid-block discards all partial bits and any pending word.
- Accumulator: ACC_W = OUT_W+CODE_W bits; bit count cnt ranges 0..OUT_W+CODE_W-1.
- Accepting a symbol (in_valid & in_ready):
  - Masked code bits [len-1:0] are appended directly below the existing cnt bits.
  - cnt += len.
  - len=0 changes nothing except in_last handling.
  - in_len > CODE_W is treated as CODE_W and sets err_len, which stays set until rst.
- in_ready = (state==RUN) & (cnt < OUT_W). Each completed word therefore costs one input bubble.
- Word transfer:
  - Condition: cnt >= OUT_W and output register free, where free means !out_valid, or out_ready is high in the same cycle.
  - Action: top OUT_W bits move to out_data, out_bytes=OUT_W/8, the accumulator shifts left by OUT_W, and cnt -= OUT_W.
  - Latency: a symbol accepted at edge N that completes a word gives out_valid=1 after edge N+1, provided the register is free.
- Output register holds stable while out_valid & !out_ready. It clears out_valid on handshake unless reloaded in the same cycle.
- FSM:
  - RUN: normal accept. Accepting with in_last=1 goes to FLUSH.
  - FLUSH (in_ready=0): full words drain as in RUN.
    - A full-word transfer leaving cnt==0 sets out_last=1, then goes to RUN.
    - If 0 < cnt < OUT_W and the register is free: emit the tail word. Tail bits sit MSB-aligned; bits from cnt up to the next byte boundary are PAD_ONES; the remaining low bits are 0. out_bytes=ceil(cnt/8), out_last=1, cnt=0, go to RUN.
    - If cnt==0 on entry (no unsent bits): emit an empty word with out_data=0, out_bytes=0, out_last=1, then go to RUN.
- Exactly one out_last word per in_last symbol. A new block may be accepted the cycle after the out_last word is loaded.
- The output word sequence must be a pure function of the symbol sequence, independent of out_ready timing.

Decomposition:
- Package vlc_pkg holds:
  - function clog2-based width helpers
  - localparams PAD_ZERO/PAD_ONE
  - typedef enum {RUN, FLUSH} vlc_state_t
- Sub-module vlc_mask_align (combinational): takes code, len and cnt. It produces the masked code shifted to its accumulator position, plus the clamped len and the clamp flag. The top level holds the registers, FSM and output stage.

Test Plan (OUT_W=32, CODE_W=16, PAD_ONES=0 unless stated):
- Reset: assert rst mid-stream with out_valid=1 -> all outputs go to reset values immediately. The next block's first word contains no stale bits.
- Packing: symbols (0x5,3),(0xABCD,16),(0x3,2),(0x7F,7),(0x1,4), out_ready=1 -> one word 0xB579BFF1, out_bytes=4, out_last=0. in_ready is low exactly one cycle after the 5th accept.
- Tail flush: (0x5,3,last) -> 0xA0000000, out_bytes=1, out_last=1. With PAD_ONES=1 -> 0xBF000000.
- Exact-fit and empty flush: (0xFFFF,16),(0x0001,16,last) -> a single word 0xFFFF0001, out_bytes=4, out_last=1, no extra word. Then (x,0,last) -> word 0, out_bytes=0, out_last=1.
- Backpressure: 40 random symbols with out_ready toggling randomly -> word sequence matches the out_ready=1 reference. Data holds stable while stalled, and in_ready drops once cnt>=32 with the register full.
- Length error: (0xFFFFF,20) -> handled as (0xFFFF,16) and err_len=1. err_len stays 1 through later valid symbols until rst.
